// File: rtl/mux_sel_arbiter.sv
// Two-channel round-robin arbiter producing the select line for a
// downstream 2:1 mux. One requester owns the mux at a time. While the
// other channel is waiting, the owner keeps the grant for at most MAX_HOLD
// consecutive cycles. Every output comes straight from a flop, so there is
// no combinational path from a request to any output.
//
// Handshake: req0/req1 are levels that the requester holds until it has
// been served. gnt0/gnt1 are the acknowledgement and appear one cycle after
// the request is sampled. A requester releases the mux by dropping its req.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [1:0]       dbg_state
);

    // One bit per grant, so the grant flags are plain state-register bits.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    // Last hold_cnt value before the owner must rotate out to a waiting channel.
    localparam int unsigned        HOLD_LAST_I = MAX_HOLD - 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST   = HOLD_LAST_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic             last_q, last_d;     // channel served most recently
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    // State, pointer, select and counter registers; reset acts asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;              // channel 0 wins the first contention
            sel_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: round-robin arbitration with a bounded hold time.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end

            GRANT0: begin
                if (!req0) begin
                    // Owner released; a release beats the hold limit.
                    last_d  = 1'b0;
                    hold_d  = '0;
                    state_d = req1 ? GRANT1 : IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    // Hold limit reached: rotate only if the other side waits.
                    hold_d = '0;
                    if (req1) begin
                        last_d  = 1'b0;
                        state_d = GRANT1;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            GRANT1: begin
                if (!req1) begin
                    last_d  = 1'b1;
                    hold_d  = '0;
                    state_d = req0 ? GRANT0 : IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (req0) begin
                        last_d  = 1'b1;
                        state_d = GRANT0;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        // Select follows the owner; it keeps its value through IDLE so the
        // downstream mux output does not glitch between grants.
        if (state_d == GRANT0) begin
            sel_d = 1'b0;
        end else if (state_d == GRANT1) begin
            sel_d = 1'b1;
        end
    end

    assign gnt0      = state_q[0];
    assign gnt1      = state_q[1];
    assign busy      = state_q[0] | state_q[1];
    assign sel       = sel_q;
    assign hold_cnt  = hold_q;
    assign dbg_state = state_q;

endmodule
